// File: rtl/addr_route_demux.sv
// Routes upstream requests to one of NoPorts master ports using addr_decode results,
// keeping responses in order by locking to one port while transactions are outstanding.
module addr_route_demux #(
    parameter int unsigned NoPorts   = 2,
    parameter int unsigned MaxTrans  = 4,
    parameter int unsigned AddrWidth = 12,
    parameter int unsigned DataWidth = 32,
    localparam int unsigned IdxWidth = (NoPorts > 1) ? $clog2(NoPorts) : 1,
    localparam int unsigned CntWidth = $clog2(MaxTrans + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               slv_req_valid_i,
    output logic                               slv_req_ready_o,
    input  logic [AddrWidth-1:0]               slv_req_addr_i,
    input  logic [DataWidth-1:0]               slv_req_data_i,
    output logic [AddrWidth-1:0]               dec_addr_o,
    input  logic [IdxWidth-1:0]                dec_idx_i,
    input  logic                               dec_valid_i,
    input  logic                               dec_error_i,
    output logic [NoPorts-1:0]                 mst_req_valid_o,
    input  logic [NoPorts-1:0]                 mst_req_ready_i,
    output logic [AddrWidth-1:0]               mst_req_addr_o,
    output logic [DataWidth-1:0]               mst_req_data_o,
    input  logic [NoPorts-1:0]                 mst_rsp_valid_i,
    output logic [NoPorts-1:0]                 mst_rsp_ready_o,
    input  logic [NoPorts-1:0][DataWidth-1:0]  mst_rsp_data_i,
    output logic                               slv_rsp_valid_o,
    input  logic                               slv_rsp_ready_i,
    output logic [DataWidth-1:0]               slv_rsp_data_o,
    output logic                               slv_rsp_err_o
);

    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxTrans);

    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [IdxWidth-1:0] lock_q, lock_d;
    logic                err_q, err_d;

    logic cnt_zero;
    logic idx_ok;
    logic route_ok;
    logic err_ok;
    logic route_hs;
    logic err_hs;
    logic rsp_hs;
    logic lock_rsp_valid;

    assign dec_addr_o     = slv_req_addr_i;
    assign mst_req_addr_o = slv_req_addr_i;
    assign mst_req_data_o = slv_req_data_i;

    assign cnt_zero = (cnt_q == '0);
    assign idx_ok   = (32'(dec_idx_i) < NoPorts);

    // A routed request may join the outstanding group only if it targets the locked port.
    assign route_ok = dec_valid_i && idx_ok && !err_q && (cnt_q < CntMax)
                      && (cnt_zero || (dec_idx_i == lock_q));
    assign err_ok   = !dec_valid_i && dec_error_i && cnt_zero && !err_q;

    assign route_hs       = route_ok && slv_req_valid_i && mst_req_ready_i[dec_idx_i];
    assign err_hs         = err_ok && slv_req_valid_i;
    assign lock_rsp_valid = !err_q && !cnt_zero && mst_rsp_valid_i[lock_q];
    assign rsp_hs         = lock_rsp_valid && slv_rsp_ready_i;

    generate
        for (genvar gi = 0; gi < NoPorts; gi++) begin : g_port
            assign mst_req_valid_o[gi] = route_ok && slv_req_valid_i
                                         && (dec_idx_i == IdxWidth'(gi));
            assign mst_rsp_ready_o[gi] = !err_q && !cnt_zero
                                         && (lock_q == IdxWidth'(gi)) && slv_rsp_ready_i;
        end
    endgenerate

    always_comb begin
        slv_req_ready_o = 1'b0;
        if (route_ok) begin
            slv_req_ready_o = mst_req_ready_i[dec_idx_i];
        end else if (err_ok) begin
            slv_req_ready_o = 1'b1;
        end
    end

    always_comb begin
        slv_rsp_valid_o = 1'b0;
        slv_rsp_err_o   = 1'b0;
        slv_rsp_data_o  = '0;
        if (err_q) begin
            slv_rsp_valid_o = 1'b1;
            slv_rsp_err_o   = 1'b1;
        end else if (!cnt_zero) begin
            slv_rsp_valid_o = mst_rsp_valid_i[lock_q];
            slv_rsp_data_o  = mst_rsp_data_i[lock_q];
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        lock_d = lock_q;
        err_d  = err_q;
        if (route_hs && !rsp_hs) begin
            cnt_d = cnt_q + CntWidth'(1);
        end else if (rsp_hs && !route_hs) begin
            cnt_d = cnt_q - CntWidth'(1);
        end
        if (route_hs) begin
            lock_d = dec_idx_i;
        end
        // The local error response is only ever issued with nothing outstanding.
        if (err_q && slv_rsp_ready_i) begin
            err_d = 1'b0;
        end else if (err_hs) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            lock_q <= '0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
            err_q  <= err_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NoPorts; gi++) begin : g_rsp_chk
            a_rsp_on_locked_port: assert property (@(posedge clk_i) disable iff (!rst_ni)
                mst_rsp_valid_i[gi] |-> (!err_q && !cnt_zero && (lock_q == IdxWidth'(gi))));
        end
    endgenerate

    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (slv_req_valid_i && !slv_req_ready_o) |=>
            (slv_req_valid_i && $stable(slv_req_addr_i) && $stable(slv_req_data_i)));

endmodule

// File: tb/tb_addr_route_demux.sv
// Scoreboard bench for addr_route_demux: models addr_decode and two response ports,
// and checks routing, port locking, full-counter stall, error responses and async reset.
module tb_addr_route_demux;

    localparam int NP = 2;
    localparam int MT = 4;
    localparam int AW = 12;
    localparam int DW = 32;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    slv_req_valid = 1'b0;
    logic                    slv_req_ready;
    logic [AW-1:0]           slv_req_addr = '0;
    logic [DW-1:0]           slv_req_data = '0;
    logic [AW-1:0]           dec_addr;
    logic [0:0]              dec_idx;
    logic                    dec_valid;
    logic                    dec_error;
    logic [NP-1:0]           mst_req_valid;
    logic [NP-1:0]           mst_req_ready = 2'b11;
    logic [AW-1:0]           mst_req_addr;
    logic [DW-1:0]           mst_req_data;
    logic [NP-1:0]           mst_rsp_valid = '0;
    logic [NP-1:0]           mst_rsp_ready;
    logic [NP-1:0][DW-1:0]   mst_rsp_data = '0;
    logic                    slv_rsp_valid;
    logic                    slv_rsp_ready = 1'b0;
    logic [DW-1:0]           slv_rsp_data;
    logic                    slv_rsp_err;

    always #5 clk = ~clk;

    addr_route_demux #(
        .NoPorts  (NP),
        .MaxTrans (MT),
        .AddrWidth(AW),
        .DataWidth(DW)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .slv_req_valid_i(slv_req_valid),
        .slv_req_ready_o(slv_req_ready),
        .slv_req_addr_i (slv_req_addr),
        .slv_req_data_i (slv_req_data),
        .dec_addr_o     (dec_addr),
        .dec_idx_i      (dec_idx),
        .dec_valid_i    (dec_valid),
        .dec_error_i    (dec_error),
        .mst_req_valid_o(mst_req_valid),
        .mst_req_ready_i(mst_req_ready),
        .mst_req_addr_o (mst_req_addr),
        .mst_req_data_o (mst_req_data),
        .mst_rsp_valid_i(mst_rsp_valid),
        .mst_rsp_ready_o(mst_rsp_ready),
        .mst_rsp_data_i (mst_rsp_data),
        .slv_rsp_valid_o(slv_rsp_valid),
        .slv_rsp_ready_i(slv_rsp_ready),
        .slv_rsp_data_o (slv_rsp_data),
        .slv_rsp_err_o  (slv_rsp_err)
    );

    // Address map of the upstream decoder; -1 marks a decode miss.
    function automatic int map_port(input logic [AW-1:0] a);
        if (a <= 12'h00F) return 0;
        if (a >= 12'h010 && a <= 12'h01F) return 1;
        if (a >= 12'hF00) return 0;
        return -1;
    endfunction

    always_comb begin
        int p;
        p         = map_port(dec_addr);
        dec_valid = (p >= 0);
        dec_error = (p < 0);
        dec_idx   = (p == 1) ? 1'b1 : 1'b0;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] pq0[$];
    logic [DW-1:0] pq1[$];
    int            credits[NP];

    // Handshakes are sampled at the falling edge; inputs only change just after rising edges.
    always @(negedge clk) begin
        rsp_t e;
        int   p;
        if (rst_n) begin
            if (slv_rsp_valid && slv_rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_rsp_err", 64'(slv_rsp_err), 64'(e.err));
                    check("sb_rsp_data", 64'(slv_rsp_data), 64'(e.data));
                    $display("rsp  data=0x%08h err=%0b", slv_rsp_data, slv_rsp_err);
                end
            end
            if (mst_rsp_valid[0] && mst_rsp_ready[0]) begin
                void'(pq0.pop_front());
                credits[0]--;
            end
            if (mst_rsp_valid[1] && mst_rsp_ready[1]) begin
                void'(pq1.pop_front());
                credits[1]--;
            end
            if (slv_req_valid && slv_req_ready) begin
                p = map_port(slv_req_addr);
                if (p < 0) begin
                    check("sb_req_route", 64'(mst_req_valid), 64'd0);
                    e.err  = 1'b1;
                    e.data = '0;
                end else begin
                    check("sb_req_route", 64'(mst_req_valid), 64'(1 << p));
                    e.err  = 1'b0;
                    e.data = slv_req_data ^ 32'hFF;
                end
                exp_q.push_back(e);
                $display("req  addr=0x%03h data=0x%08h port=%0d", slv_req_addr, slv_req_data, p);
            end
            if (mst_req_valid[0] && mst_req_ready[0]) pq0.push_back(mst_req_data);
            if (mst_req_valid[1] && mst_req_ready[1]) pq1.push_back(mst_req_data);
        end
    end

    // Port models answer each request with its payload XOR 0xFF, gated by credits.
    always @(posedge clk) begin
        #2;
        mst_rsp_valid[0] = rst_n && (credits[0] > 0) && (pq0.size() > 0);
        mst_rsp_data[0]  = (pq0.size() > 0) ? (pq0[0] ^ 32'hFF) : '0;
        mst_rsp_valid[1] = rst_n && (credits[1] > 0) && (pq1.size() > 0);
        mst_rsp_data[1]  = (pq1.size() > 0) ? (pq1[0] ^ 32'hFF) : '0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cnt0(input string tag);
        for (int i = 0; i < 20; i++) begin
            tick();
            #2;
            if (dut.cnt_q == '0) break;
        end
        check(tag, 64'(dut.cnt_q), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        credits[0] = 0;
        credits[1] = 0;

        // Reset state
        #23;
        check("rst_mst_req_valid", 64'(mst_req_valid), 64'd0);
        check("rst_mst_rsp_ready", 64'(mst_rsp_ready), 64'd0);
        check("rst_slv_rsp_valid", 64'(slv_rsp_valid), 64'd0);
        check("rst_slv_rsp_err", 64'(slv_rsp_err), 64'd0);
        check("rst_slv_rsp_data", 64'(slv_rsp_data), 64'd0);
        check("rst_cnt", 64'(dut.cnt_q), 64'd0);
        #4 rst_n = 1'b1;
        slv_rsp_ready = 1'b1;

        // Single routed request to port 0 and its response
        tick();
        slv_req_valid = 1'b1; slv_req_addr = 12'h005; slv_req_data = 32'hA5;
        #2;
        check("t1_mvalid", 64'(mst_req_valid), 64'h1);
        check("t1_ready", 64'(slv_req_ready), 64'd1);
        tick();
        slv_req_valid = 1'b0;
        #2;
        check("t1_cnt1", 64'(dut.cnt_q), 64'd1);
        credits[0] = 1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            #2;
            seen = slv_rsp_valid;
        end
        check("t1_rsp_valid", 64'(slv_rsp_valid), 64'd1);
        check("t1_rsp_data", 64'(slv_rsp_data), 64'h5A);
        check("t1_rsp_err", 64'(slv_rsp_err), 64'd0);
        tick();
        #2;
        check("t1_cnt0", 64'(dut.cnt_q), 64'd0);

        // Port switch waits for the outstanding port-0 response
        tick();
        slv_req_valid = 1'b1; slv_req_addr = 12'h005; slv_req_data = 32'h11;
        #2;
        check("t2_first_ready", 64'(slv_req_ready), 64'd1);
        tick();
        slv_req_addr = 12'h013; slv_req_data = 32'h22;
        #2;
        check("t2_stall_ready", 64'(slv_req_ready), 64'd0);
        check("t2_stall_mvalid", 64'(mst_req_valid), 64'd0);
        tick();
        #2;
        check("t2_stall_ready2", 64'(slv_req_ready), 64'd0);
        credits[0] = 1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            #2;
            seen = slv_req_ready;
        end
        check("t2_switch_ready", 64'(slv_req_ready), 64'd1);
        check("t2_switch_mvalid", 64'(mst_req_valid), 64'h2);
        check("t2_switch_cnt", 64'(dut.cnt_q), 64'd0);
        tick();
        slv_req_valid = 1'b0;
        credits[1] = 1;
        wait_cnt0("t2_drain");

        // Full counter: four outstanding, fifth stalls until one response
        for (int i = 0; i < MT; i++) begin
            tick();
            slv_req_valid = 1'b1; slv_req_addr = 12'hF10; slv_req_data = 32'h30 + 32'(i);
            #2;
            check("t3_fill_ready", 64'(slv_req_ready), 64'd1);
        end
        tick();
        slv_req_data = 32'h34;
        #2;
        check("t3_full_stall", 64'(slv_req_ready), 64'd0);
        check("t3_cnt_full", 64'(dut.cnt_q), 64'd4);
        credits[0] = 1;
        tick();
        #2;
        check("t3_rsp_same_cycle_valid", 64'(slv_rsp_valid), 64'd1);
        check("t3_rsp_same_cycle_ready", 64'(slv_req_ready), 64'd0);
        tick();
        #2;
        check("t3_unblock_ready", 64'(slv_req_ready), 64'd1);
        check("t3_unblock_mvalid", 64'(mst_req_valid), 64'h1);
        check("t3_unblock_cnt", 64'(dut.cnt_q), 64'd3);
        tick();
        slv_req_valid = 1'b0;
        credits[0] = 4;
        wait_cnt0("t3_drain");

        // Decode miss answered locally with an error response
        slv_rsp_ready = 1'b0;
        tick();
        slv_req_valid = 1'b1; slv_req_addr = 12'h100; slv_req_data = 32'h77;
        #2;
        check("t4_ready", 64'(slv_req_ready), 64'd1);
        check("t4_mvalid", 64'(mst_req_valid), 64'd0);
        check("t4_rsp_not_yet", 64'(slv_rsp_valid), 64'd0);
        tick();
        slv_req_valid = 1'b0;
        #2;
        check("t4_rsp_valid", 64'(slv_rsp_valid), 64'd1);
        check("t4_rsp_err", 64'(slv_rsp_err), 64'd1);
        check("t4_rsp_data", 64'(slv_rsp_data), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            #2;
            check("t4_rsp_hold", 64'({slv_rsp_valid, slv_rsp_err}), 64'h3);
        end
        slv_rsp_ready = 1'b1;
        tick();
        #2;
        check("t4_rsp_cleared", 64'(slv_rsp_valid), 64'd0);

        // Asynchronous reset with two outstanding transactions
        tick();
        slv_req_valid = 1'b1; slv_req_addr = 12'h005; slv_req_data = 32'h51;
        tick();
        slv_req_data = 32'h52;
        tick();
        slv_req_valid = 1'b0;
        #2;
        check("t5_cnt2", 64'(dut.cnt_q), 64'd2);
        check("t5_rsp_ready_pre", 64'(mst_rsp_ready), 64'h1);
        rst_n = 1'b0;
        exp_q.delete();
        pq0.delete();
        pq1.delete();
        credits[0] = 0;
        credits[1] = 0;
        #1;
        check("t5_rst_cnt", 64'(dut.cnt_q), 64'd0);
        check("t5_rst_err", 64'(dut.err_q), 64'd0);
        check("t5_rst_lock", 64'(dut.lock_q), 64'd0);
        check("t5_rst_rsp_ready", 64'(mst_rsp_ready), 64'd0);
        check("t5_rst_rsp_valid", 64'(slv_rsp_valid), 64'd0);
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        slv_req_valid = 1'b1; slv_req_addr = 12'h015; slv_req_data = 32'h66;
        #2;
        check("t5_post_ready", 64'(slv_req_ready), 64'd1);
        check("t5_post_mvalid", 64'(mst_req_valid), 64'h2);
        tick();
        slv_req_valid = 1'b0;
        credits[1] = 1;
        wait_cnt0("t5_drain");

        tick();
        tick();
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
